windowed_event_detector: RTL
============================

# windowed_event_detector

Parametrised moving-sum (boxcar) event detector for the HSMC ADC sample stream. It generalises the fixed-depth cumulative adder in four ways: a runtime window length, a RAM-style circular buffer, hysteresis thresholds with holdoff, and per-event capture of peak and width. It sits between the ADC sample strobe and the event/readout logic. It produces one event record per detected pulse.

## Interface
- MAX_SAMPLES, 512, buffer depth and maximum window; power of two, ≥2
- DWIDTH, 14, unsigned input sample width
- WWIDTH, 16, event width counter width
- Derived: AWIDTH = clog2(MAX_SAMPLES); SWIDTH = DWIDTH + AWIDTH (exact sum width, no overflow possible)

Ports:
- CLOCK  in  1  single clock; all logic on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- CLEAR  in  1  synchronous flush; latches WIN_LEN
- ENABLE  in  1  sample strobe; one sample per high cycle
- DATA_IN  in  DWIDTH  unsigned sample
- WIN_LEN  in  AWIDTH+1  window length; 0 treated as 1, >MAX_SAMPLES clamped to MAX_SAMPLES
- TH_HI  in  SWIDTH  rise threshold (strict >)
- TH_LO  in  SWIDTH  fall threshold (strict <)
- HOLDOFF  in  16  enabled samples to ignore after an event ends
- CUSUM  out  SWIDTH  current window sum
- SUM_VALID  out  1  window filled since last reset/CLEAR
- TRIGGER  out  1  hysteretic level detect
- EVENT_VALID  out  1  one-cycle pulse at event end
- EVENT_PEAK  out  SWIDTH  max CUSUM during last event
- EVENT_WIDTH  out  WWIDTH  samples with TRIGGER high in last event, saturating
- EVENT_COUNT  out  16  completed events, saturating at 0xFFFF

## Operation
- Reset: all outputs 0. The latched window win_q is MAX_SAMPLES, the write pointer is 0, and state is FILL. Buffer contents do not need reset.
- CLEAR: loads win_q from the sanitised WIN_LEN. Zeroes the sum, pointer, fill counter, SUM_VALID, TRIGGER, holdoff counter, EVENT_VALID and in-progress peak/width. State goes to FILL. EVENT_COUNT, EVENT_PEAK and EVENT_WIDTH are kept. If CLEAR is asserted with ENABLE, CLEAR wins and the sample is dropped. CLEAR during an event emits no record.
- Buffer: each enabled sample reads old = buf[ptr], then writes buf[ptr] = DATA_IN (read-before-write, same cycle). ptr wraps from win_q-1 to 0.
- Sum: sum_next = sum + DATA_IN - (FILL ? 0 : old). Stale buffer data never contributes.
- FILL: counts enabled samples. On the win_q-th sample: SUM_VALID goes to 1, state goes to IDLE, and thresholds are evaluated on that same sum_next.
- IDLE: if sum_next > TH_HI, TRIGGER goes to 1, state goes to EVENT, peak = sum_next, width = 1.
- EVENT, sum_next < TH_LO: TRIGGER goes to 0. EVENT_VALID pulses, EVENT_PEAK/EVENT_WIDTH are loaded, and EVENT_COUNT increments. The holdoff counter loads HOLDOFF; state goes to HOLDOFF, or to IDLE if HOLDOFF = 0.
- EVENT, otherwise: peak = max(peak, sum_next); width increments, saturating.
- HOLDOFF: counts down once per enabled sample. At 0, state goes to IDLE. The sample that reaches 0 is not evaluated. TRIGGER is held at 0.
- Misconfigured TH_LO > TH_HI still behaves deterministically, because rise is only checked in IDLE and fall only in EVENT.
- ENABLE low: all state and outputs hold; EVENT_VALID is 0.

## Timing
- CUSUM, SUM_VALID, TRIGGER, EVENT_* all update on the edge that consumes the enabled sample. Latency is 1 cycle from sample to output, and CUSUM includes that sample.
- EVENT_VALID is high for exactly one cycle, on the edge where TRIGGER falls.
- The ending sample (the one with sum < TH_LO) is excluded from peak and width.
- Back-to-back ENABLE at the full clock rate is supported. There is no throughput gap.
- RESET_N deasserting mid-event gives a clean FILL start. No EVENT_VALID is issued.

## Test plan
- Fill/slide: WIN_LEN=4, CLEAR, samples 1,2,3,4,5,6 -> CUSUM 1,3,6,10,14,18. SUM_VALID rises with the 4th sample.
- Hysteresis: WIN_LEN=1, TH_HI=100, TH_LO=50, HOLDOFF=0, samples 60,101,80,50,49,60 -> TRIGGER 0,1,1,1,0,0. EVENT_VALID pulses on the 49 sample with PEAK=101, WIDTH=3, COUNT=1.
- Holdoff: same setup with HOLDOFF=2; after the event, samples 200,200,200 -> TRIGGER 0,0,1.
- Full scale: WIN_LEN=512, 512× DATA_IN=16383 -> CUSUM=8388096 with no wrap. Then 512 zeros -> CUSUM=0.
- Sparse strobe: samples from the first scenario with 0–3 idle cycles between ENABLEs -> identical CUSUM sequence, with outputs holding during the gaps.
- Corner cases:
  - WIN_LEN=0 behaves as window 1.
  - CLEAR+ENABLE in the same cycle drops the sample.
  - RESET_N pulsed mid-event -> all outputs 0, no EVENT_VALID, and EVENT_COUNT 0.

Source files
------------

// File: rtl/windowed_event_detector.sv
// Moving-sum (boxcar) event detector for the ADC sample stream.
// A circular buffer of the last win_q samples keeps a running window sum.
// Hysteretic thresholds with holdoff turn that sum into events, and each
// event yields one record holding its peak sum and its width.
module windowed_event_detector #(
  parameter int unsigned MAX_SAMPLES = 512,
  parameter int unsigned DWIDTH      = 14,
  parameter int unsigned WWIDTH      = 16,
  localparam int unsigned AWIDTH     = $clog2(MAX_SAMPLES),
  localparam int unsigned SWIDTH     = DWIDTH + AWIDTH
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              CLEAR,
  input  logic              ENABLE,
  input  logic [DWIDTH-1:0] DATA_IN,
  input  logic [AWIDTH:0]   WIN_LEN,
  input  logic [SWIDTH-1:0] TH_HI,
  input  logic [SWIDTH-1:0] TH_LO,
  input  logic [15:0]       HOLDOFF,
  output logic [SWIDTH-1:0] CUSUM,
  output logic              SUM_VALID,
  output logic              TRIGGER,
  output logic              EVENT_VALID,
  output logic [SWIDTH-1:0] EVENT_PEAK,
  output logic [WWIDTH-1:0] EVENT_WIDTH,
  output logic [15:0]       EVENT_COUNT
);

  localparam logic [AWIDTH:0] WinOne = (AWIDTH + 1)'(1);
  localparam logic [AWIDTH:0] WinMax = (AWIDTH + 1)'(MAX_SAMPLES);

  typedef enum logic [1:0] {StFill, StIdle, StEvent, StHoldoff} state_e;

  state_e              state_q;
  logic [AWIDTH:0]     win_q;
  logic [AWIDTH:0]     win_sane;
  logic [AWIDTH-1:0]   ptr_q;
  logic [AWIDTH-1:0]   ptr_next;
  logic [AWIDTH:0]     fill_q;
  logic [AWIDTH:0]     fill_next;
  logic [SWIDTH-1:0]   sum_q;
  logic [SWIDTH-1:0]   sum_next;
  logic [SWIDTH-1:0]   old_ext;
  logic                rise;
  logic                fall;
  logic [15:0]         hold_q;
  logic [15:0]         hold_dec;
  logic [SWIDTH-1:0]   peak_q;
  logic [WWIDTH-1:0]   width_q;
  logic                sum_valid_q;
  logic                trigger_q;
  logic                event_valid_q;
  logic [SWIDTH-1:0]   event_peak_q;
  logic [WWIDTH-1:0]   event_width_q;
  logic [15:0]         event_count_q;
  logic [DWIDTH-1:0]   buf_mem [MAX_SAMPLES];

  // Sanitise the requested window: 0 means 1, oversize clamps to the buffer depth.
  always_comb begin
    win_sane = WIN_LEN;
    if (WIN_LEN == '0) begin
      win_sane = WinOne;
    end else if (WIN_LEN > WinMax) begin
      win_sane = WinMax;
    end
  end

  // Datapath for the sample being consumed this cycle (read-before-write on the buffer).
  always_comb begin
    old_ext  = SWIDTH'(buf_mem[ptr_q]);
    sum_next = sum_q + SWIDTH'(DATA_IN);
    // While filling, the slot being overwritten holds stale data and must not be removed.
    if (state_q != StFill) begin
      sum_next = sum_next - old_ext;
    end
    ptr_next  = ({1'b0, ptr_q} == (win_q - WinOne)) ? '0 : ptr_q + AWIDTH'(1);
    fill_next = fill_q + WinOne;
    hold_dec  = hold_q - 16'd1;
    rise      = sum_next > TH_HI;
    fall      = sum_next < TH_LO;
  end

  // Sample buffer; contents need no reset since fill never reads stale slots.
  always_ff @(posedge CLOCK) begin
    if (ENABLE && !CLEAR) begin
      buf_mem[ptr_q] <= DATA_IN;
    end
  end

  // Control FSM, running sum and event record registers.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= StFill;
      win_q         <= WinMax;
      ptr_q         <= '0;
      fill_q        <= '0;
      sum_q         <= '0;
      hold_q        <= '0;
      peak_q        <= '0;
      width_q       <= '0;
      sum_valid_q   <= 1'b0;
      trigger_q     <= 1'b0;
      event_valid_q <= 1'b0;
      event_peak_q  <= '0;
      event_width_q <= '0;
      event_count_q <= '0;
    end else if (CLEAR) begin
      // Flush the window; completed-event outputs are kept.
      state_q       <= StFill;
      win_q         <= win_sane;
      ptr_q         <= '0;
      fill_q        <= '0;
      sum_q         <= '0;
      hold_q        <= '0;
      peak_q        <= '0;
      width_q       <= '0;
      sum_valid_q   <= 1'b0;
      trigger_q     <= 1'b0;
      event_valid_q <= 1'b0;
    end else begin
      event_valid_q <= 1'b0;
      if (ENABLE) begin
        sum_q <= sum_next;
        ptr_q <= ptr_next;
        unique case (state_q)
          StFill: begin
            fill_q <= fill_next;
            if (fill_next == win_q) begin
              sum_valid_q <= 1'b1;
              if (rise) begin
                trigger_q <= 1'b1;
                peak_q    <= sum_next;
                width_q   <= WWIDTH'(1);
                state_q   <= StEvent;
              end else begin
                state_q   <= StIdle;
              end
            end
          end
          StIdle: begin
            if (rise) begin
              trigger_q <= 1'b1;
              peak_q    <= sum_next;
              width_q   <= WWIDTH'(1);
              state_q   <= StEvent;
            end
          end
          StEvent: begin
            if (fall) begin
              // The ending sample is excluded from the record.
              trigger_q     <= 1'b0;
              event_valid_q <= 1'b1;
              event_peak_q  <= peak_q;
              event_width_q <= width_q;
              if (event_count_q != 16'hFFFF) begin
                event_count_q <= event_count_q + 16'd1;
              end
              hold_q  <= HOLDOFF;
              state_q <= (HOLDOFF == 16'd0) ? StIdle : StHoldoff;
            end else begin
              if (sum_next > peak_q) begin
                peak_q <= sum_next;
              end
              if (width_q != {WWIDTH{1'b1}}) begin
                width_q <= width_q + WWIDTH'(1);
              end
            end
          end
          StHoldoff: begin
            // The sample that exhausts the holdoff is not evaluated.
            hold_q <= hold_dec;
            if (hold_dec == 16'd0) begin
              state_q <= StIdle;
            end
          end
          default: state_q <= StFill;
        endcase
      end
    end
  end

  assign CUSUM       = sum_q;
  assign SUM_VALID   = sum_valid_q;
  assign TRIGGER     = trigger_q;
  assign EVENT_VALID = event_valid_q;
  assign EVENT_PEAK  = event_peak_q;
  assign EVENT_WIDTH = event_width_q;
  assign EVENT_COUNT = event_count_q;

endmodule
